pq_cmd_arbiter: RTL and testbench
=================================

PQ_CMD_ARBITER -- requirements
Module: pq_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requester channels (2..16).
REQ-002 SHALL have parameter DEPTH, default QUEUE_DEPTH; ID_WIDTH = clog2(DEPTH)+1.
REQ-003 SHALL have parameter DW, default DATA_WIDTH, entry data width.
REQ-004 SHALL have parameter INIT_CYCLES, default 16, post-reset quiet cycles before service.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk_i input 1 (rising edge), then rst_i input 1.
REQ-006 SHALL have ch_valid_i in NUM_CH, ch_ready_o out NUM_CH, ch_cmd_i in 2*NUM_CH, ch_data_i in DW*NUM_CH, ch_id_i in ID_WIDTH*NUM_CH (per-channel request).
REQ-007 SHALL have rsp_valid_o out 1, rsp_ch_o out clog2(NUM_CH), rsp_cmd_o out 2, rsp_data_o out DW, rsp_id_o out ID_WIDTH, rsp_err_o out 1 (response).
REQ-008 SHALL have flush_i in 1 (flush request), busy_o out 1 (not in RUN).
REQ-009 SHALL have pq_push_o, pq_pop_o, pq_drop_o out 1; pq_data_o out DW; pq_drop_id_o out ID_WIDTH (queue command side).
REQ-010 SHALL have pq_push_rdy_i, pq_pop_rdy_i, pq_drop_rdy_i, pq_full_i, pq_empty_i in 1; pq_data_i in DW; pq_push_id_i in ID_WIDTH (queue status side).

Function
REQ-011 SHALL decode ch_cmd: 01 PUSH, 10 POP, 11 DROP, 00 reserved.
REQ-012 SHALL deem a channel eligible when valid and: PUSH with push_rdy & !full; POP with pop_rdy & !empty; DROP with drop_rdy; reserved always.
REQ-013 SHALL grant at most one eligible channel per cycle, round-robin starting after the last granted channel; pointer resets to channel 0.
REQ-014 SHALL assert ch_ready_o only for the granted channel, combinationally in the grant cycle.
REQ-015 SHALL drive exactly one pq_*_o strobe combinationally in the grant cycle, with pq_data_o/pq_drop_id_o from the granted channel; reserved commands drive none.
REQ-016 SHALL assert rsp_valid_o one cycle after grant for one cycle, with channel, command, pq_data_i (POP) and pq_push_id_i (PUSH) registered from the grant cycle; other fields zero.
REQ-017 SHALL assert rsp_err_o with the response of a reserved command.
REQ-018 SHALL have states INIT, RUN, FLUSH; reset enters INIT.
REQ-019 INIT: count INIT_CYCLES cycles, no grants, all outputs low, then RUN.
REQ-020 RUN: flush_i high -> FLUSH next cycle, no grant in that cycle (flush wins).
REQ-021 FLUSH: ch_ready_o all low; pq_pop_o = pq_pop_rdy_i & !pq_empty_i; no responses; pq_empty_i high -> RUN.
REQ-022 SHALL keep ineligible requests pending indefinitely (e.g. POP on empty) without blocking others.
REQ-023 busy_o SHALL be high in INIT and FLUSH.

Reset
REQ-024 SHALL, on rst_i, immediately clear all outputs to zero, state to INIT, pointer to 0, pending response discarded.
REQ-025 Reset mid-FLUSH or mid-response SHALL lose that operation; no recovery.

Configuration
REQ-026 With PQ_ARB_STATS_EN defined, SHALL add output grant_cnt_o (32*NUM_CH), per-channel saturating grant counters, cleared by reset.
REQ-027 Without PQ_ARB_STATS_EN, port and counters SHALL be absent; other behaviour identical.

Structure
REQ-028 pq_pkg SHALL hold pq_cmd_e (2-bit command enum) and arb_state_e.
REQ-029 SHALL instantiate one sub-module pq_rr_arb (parametrised round-robin grant, one-hot output).

Verification
REQ-030 Reset release, INIT_CYCLES=16: no ch_ready_o before cycle 16; busy_o falls at cycle 16.
REQ-031 All 4 channels PUSH continuously: grants 0,1,2,3,0; each rsp_ch_o one cycle after its grant, rsp_id_o = pq_push_id_i.
REQ-032 Ch1 POP, pq_empty_i=1; ch2 PUSH: ch2 granted, ch1 waits; empty falls -> ch1 granted, rsp_data_o = pq_data_i.
REQ-033 Ch0 cmd 00: ch_ready_o[0] high, no pq strobe, rsp_err_o=1 next cycle.
REQ-034 flush_i with 3 entries, ch0 valid: no grant; 3 pq_pop_o pulses; RUN on empty; then ch0 granted.
REQ-035 rst_i asserted cycle after grant: rsp_valid_o low immediately; INIT re-entered; grant_cnt_o zero (if enabled).

Source files
------------

// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared command/state types and default sizes for the priority-queue command arbiter
package pq_pkg;

    localparam int QUEUE_DEPTH = 8;
    localparam int DATA_WIDTH  = 32;

    typedef enum logic [1:0] {
        CMD_RSVD = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_DROP = 2'b11
    } pq_cmd_e;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pq_rr_arb.sv
// rtl/pq_rr_arb.sv - round-robin one-hot grant, search starts after the last granted requester
module pq_rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan requesters starting at ptr with wrap; first hit wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    // Move the start point just past whichever requester was granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/pq_cmd_arbiter.sv
// rtl/pq_cmd_arbiter.sv - multi-channel command arbiter in front of a priority queue; optional PQ_ARB_STATS_EN grant counters
module pq_cmd_arbiter
    import pq_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int DEPTH       = QUEUE_DEPTH,
    parameter  int DW          = DATA_WIDTH,
    parameter  int INIT_CYCLES = 16,
    localparam int ID_WIDTH    = $clog2(DEPTH) + 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_CH-1:0]      ch_valid_i,
    output logic [NUM_CH-1:0]      ch_ready_o,
    input  logic [2*NUM_CH-1:0]    ch_cmd_i,
    input  logic [DW*NUM_CH-1:0]   ch_data_i,
    input  logic [ID_WIDTH*NUM_CH-1:0] ch_id_i,
    output logic                   rsp_valid_o,
    output logic [CH_W-1:0]        rsp_ch_o,
    output logic [1:0]             rsp_cmd_o,
    output logic [DW-1:0]          rsp_data_o,
    output logic [ID_WIDTH-1:0]    rsp_id_o,
    output logic                   rsp_err_o,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   pq_push_o,
    output logic                   pq_pop_o,
    output logic                   pq_drop_o,
    output logic [DW-1:0]          pq_data_o,
    output logic [ID_WIDTH-1:0]    pq_drop_id_o,
    input  logic                   pq_push_rdy_i,
    input  logic                   pq_pop_rdy_i,
    input  logic                   pq_drop_rdy_i,
    input  logic                   pq_full_i,
    input  logic                   pq_empty_i,
    input  logic [DW-1:0]          pq_data_i,
    input  logic [ID_WIDTH-1:0]    pq_push_id_i
`ifdef PQ_ARB_STATS_EN
    ,
    output logic [32*NUM_CH-1:0]   grant_cnt_o
`endif
);

    localparam int CW = $clog2(INIT_CYCLES + 1) + 1;

    arb_state_e          state, state_nxt;
    logic [CW-1:0]       init_cnt;
    logic [NUM_CH-1:0]   elig;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   grant;
    logic                granted;
    logic [CH_W-1:0]     g_idx;
    pq_cmd_e             g_cmd;
    logic [DW-1:0]       g_data;
    logic [ID_WIDTH-1:0] g_id;
    pq_cmd_e             c_cmd;

    // Per-channel eligibility from the command and the queue status it depends on.
    always_comb begin
        elig  = '0;
        c_cmd = CMD_RSVD;
        for (int c = 0; c < NUM_CH; c++) begin
            c_cmd = pq_cmd_e'(ch_cmd_i[2*c +: 2]);
            case (c_cmd)
                CMD_PUSH: elig[c] = ch_valid_i[c] & pq_push_rdy_i & ~pq_full_i;
                CMD_POP:  elig[c] = ch_valid_i[c] & pq_pop_rdy_i & ~pq_empty_i;
                CMD_DROP: elig[c] = ch_valid_i[c] & pq_drop_rdy_i;
                default:  elig[c] = ch_valid_i[c];
            endcase
        end
    end

    // A flush request takes the cycle, so nothing is offered to the arbiter then.
    assign req = (state == ST_RUN && !flush_i) ? elig : '0;

    pq_rr_arb #(.N(NUM_CH)) u_rr_arb (
        .clk   (clk_i),
        .rst   (rst_i),
        .req   (req),
        .grant (grant)
    );

    assign granted = |grant;

    // Pull the winning channel's fields out of the packed request buses.
    always_comb begin
        g_idx  = '0;
        g_cmd  = CMD_RSVD;
        g_data = '0;
        g_id   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                g_idx  = CH_W'(c);
                g_cmd  = pq_cmd_e'(ch_cmd_i[2*c +: 2]);
                g_data = ch_data_i[DW*c +: DW];
                g_id   = ch_id_i[ID_WIDTH*c +: ID_WIDTH];
            end
        end
    end

    // State register and the INIT quiet-period counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end else begin
                init_cnt <= '0;
            end
        end
    end

    // Next state plus the queue-side strobes and channel handshakes.
    always_comb begin
        state_nxt    = state;
        ch_ready_o   = '0;
        pq_push_o    = 1'b0;
        pq_pop_o     = 1'b0;
        pq_drop_o    = 1'b0;
        pq_data_o    = '0;
        pq_drop_id_o = '0;
        busy_o       = 1'b1;
        case (state)
            ST_INIT: begin
                if (init_cnt >= CW'(INIT_CYCLES - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_o = 1'b0;
                if (flush_i) begin
                    state_nxt = ST_FLUSH;
                end else if (granted) begin
                    ch_ready_o   = grant;
                    pq_push_o    = (g_cmd == CMD_PUSH);
                    pq_pop_o     = (g_cmd == CMD_POP);
                    pq_drop_o    = (g_cmd == CMD_DROP);
                    pq_data_o    = g_data;
                    pq_drop_id_o = g_id;
                end
            end
            ST_FLUSH: begin
                pq_pop_o = pq_pop_rdy_i & ~pq_empty_i;
                if (pq_empty_i) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // One-cycle response registered from the grant cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_ch_o    <= '0;
            rsp_cmd_o   <= '0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= |ch_ready_o;
            rsp_ch_o    <= '0;
            rsp_cmd_o   <= '0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
            rsp_err_o   <= 1'b0;
            if (|ch_ready_o) begin
                rsp_ch_o  <= g_idx;
                rsp_cmd_o <= g_cmd;
                rsp_err_o <= (g_cmd == CMD_RSVD);
                if (g_cmd == CMD_POP) begin
                    rsp_data_o <= pq_data_i;
                end
                if (g_cmd == CMD_PUSH) begin
                    rsp_id_o <= pq_push_id_i;
                end
            end
        end
    end

`ifdef PQ_ARB_STATS_EN
    // Saturating per-channel grant counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_cnt_o <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_ready_o[c] && grant_cnt_o[32*c +: 32] != 32'hFFFF_FFFF) begin
                    grant_cnt_o[32*c +: 32] <= grant_cnt_o[32*c +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pq_cmd_arbiter.sv
// tb/tb_pq_cmd_arbiter.sv - directed self-checking bench for pq_cmd_arbiter
module tb_pq_cmd_arbiter;

    localparam int NCH = 4;
    localparam int DWB = 32;
    localparam int IDW = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH-1:0]     ch_valid;
    logic [NCH-1:0]     ch_ready;
    logic [2*NCH-1:0]   ch_cmd;
    logic [DWB*NCH-1:0] ch_data;
    logic [IDW*NCH-1:0] ch_id;
    logic               rsp_valid;
    logic [1:0]         rsp_ch;
    logic [1:0]         rsp_cmd;
    logic [DWB-1:0]     rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_err;
    logic               flush;
    logic               busy;
    logic               pq_push, pq_pop, pq_drop;
    logic [DWB-1:0]     pq_data_out;
    logic [IDW-1:0]     pq_drop_id;
    logic               push_rdy, pop_rdy, drop_rdy, full, empty;
    logic [DWB-1:0]     pq_data_in;
    logic [IDW-1:0]     push_id;
`ifdef PQ_ARB_STATS_EN
    logic [32*NCH-1:0]  grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pq_cmd_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ch_valid_i    (ch_valid),
        .ch_ready_o    (ch_ready),
        .ch_cmd_i      (ch_cmd),
        .ch_data_i     (ch_data),
        .ch_id_i       (ch_id),
        .rsp_valid_o   (rsp_valid),
        .rsp_ch_o      (rsp_ch),
        .rsp_cmd_o     (rsp_cmd),
        .rsp_data_o    (rsp_data),
        .rsp_id_o      (rsp_id),
        .rsp_err_o     (rsp_err),
        .flush_i       (flush),
        .busy_o        (busy),
        .pq_push_o     (pq_push),
        .pq_pop_o      (pq_pop),
        .pq_drop_o     (pq_drop),
        .pq_data_o     (pq_data_out),
        .pq_drop_id_o  (pq_drop_id),
        .pq_push_rdy_i (push_rdy),
        .pq_pop_rdy_i  (pop_rdy),
        .pq_drop_rdy_i (drop_rdy),
        .pq_full_i     (full),
        .pq_empty_i    (empty),
        .pq_data_i     (pq_data_in),
        .pq_push_id_i  (push_id)
`ifdef PQ_ARB_STATS_EN
        ,
        .grant_cnt_o   (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst        = 1'b1;
        ch_valid   = 4'hF;
        ch_cmd     = 8'b01_01_01_01;
        ch_data    = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        ch_id      = '0;
        flush      = 1'b0;
        push_rdy   = 1'b1;
        pop_rdy    = 1'b1;
        drop_rdy   = 1'b1;
        full       = 1'b0;
        empty      = 1'b1;
        pq_data_in = '0;
        push_id    = 4'd3;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1 || ch_ready !== 4'h0 || rsp_valid !== 1'b0 || pq_push !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b ready=%b rsp_valid=%b push=%b expected 1 0000 0 0",
                     busy, ch_ready, rsp_valid, pq_push);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(posedge clk);
            #2;
            checks++;
            if (busy !== 1'b1 || ch_ready !== 4'h0) begin
                errors++;
                $display("FAIL init_quiet cycle=%0d busy=%b ready=%b expected 1 0000", k, busy, ch_ready);
            end
        end
        @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || ch_ready !== 4'b0001) begin
            errors++;
            $display("FAIL init_done busy=%b ready=%b expected 0 0001", busy, ch_ready);
        end
    endtask

    task automatic test_push_rr();
        logic [3:0]  exp_ready;
        logic [31:0] exp_data;
        for (int i = 0; i < 5; i++) begin
            exp_ready = 4'b0001 << (i % 4);
            exp_data  = 32'hA000_0000 + 32'(i % 4);
            checks++;
            if (ch_ready !== exp_ready || pq_push !== 1'b1 || pq_pop !== 1'b0 || pq_data_out !== exp_data) begin
                errors++;
                $display("FAIL rr_grant step=%0d ready=%b push=%b data=%h expected %b 1 %h",
                         i, ch_ready, pq_push, pq_data_out, exp_ready, exp_data);
            end
            @(posedge clk);
            #1 push_id = 4'(i + 4);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_ch !== 2'(i % 4) || rsp_cmd !== 2'b01 ||
                rsp_id !== 4'(i + 3) || rsp_err !== 1'b0 || rsp_data !== 32'h0) begin
                errors++;
                $display("FAIL rr_rsp step=%0d valid=%b ch=%0d cmd=%b id=%0d err=%b data=%h expected 1 %0d 01 %0d 0 0",
                         i, rsp_valid, rsp_ch, rsp_cmd, rsp_id, rsp_err, rsp_data, i % 4, i + 3);
            end
        end
        ch_valid = 4'h0;
    endtask

    task automatic test_pop_wait();
        ch_valid = 4'b0110;
        ch_cmd   = 8'b00_01_10_00;
        empty    = 1'b1;
        push_id  = 4'hA;
        #1;
        checks++;
        if (ch_ready !== 4'b0100 || pq_push !== 1'b1 || pq_pop !== 1'b0) begin
            errors++;
            $display("FAIL pop_blocked_grant ready=%b push=%b pop=%b expected 0100 1 0", ch_ready, pq_push, pq_pop);
        end
        @(posedge clk);
        #1 ch_valid = 4'b0010;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ch !== 2'd2 || rsp_id !== 4'hA || ch_ready !== 4'h0) begin
            errors++;
            $display("FAIL pop_wait_push_rsp valid=%b ch=%0d id=%h ready=%b expected 1 2 a 0000",
                     rsp_valid, rsp_ch, rsp_id, ch_ready);
        end
        empty      = 1'b0;
        pq_data_in = 32'hCAFE_0001;
        #1;
        checks++;
        if (ch_ready !== 4'b0010 || pq_pop !== 1'b1 || pq_push !== 1'b0) begin
            errors++;
            $display("FAIL pop_grant ready=%b pop=%b push=%b expected 0010 1 0", ch_ready, pq_pop, pq_push);
        end
        @(posedge clk);
        #1 ch_valid = 4'h0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ch !== 2'd1 || rsp_cmd !== 2'b10 ||
            rsp_data !== 32'hCAFE_0001 || rsp_id !== 4'h0) begin
            errors++;
            $display("FAIL pop_rsp valid=%b ch=%0d cmd=%b data=%h id=%h expected 1 1 10 cafe0001 0",
                     rsp_valid, rsp_ch, rsp_cmd, rsp_data, rsp_id);
        end
    endtask

    task automatic test_drop();
        ch_valid = 4'b1000;
        ch_cmd   = 8'b11_00_00_00;
        ch_id    = 16'h5000;
        #1;
        checks++;
        if (ch_ready !== 4'b1000 || pq_drop !== 1'b1 || pq_drop_id !== 4'h5 || pq_push !== 1'b0 || pq_pop !== 1'b0) begin
            errors++;
            $display("FAIL drop_grant ready=%b drop=%b drop_id=%h push=%b pop=%b expected 1000 1 5 0 0",
                     ch_ready, pq_drop, pq_drop_id, pq_push, pq_pop);
        end
        @(posedge clk);
        #1 ch_valid = 4'h0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ch !== 2'd3 || rsp_cmd !== 2'b11 || rsp_data !== 32'h0 ||
            rsp_id !== 4'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL drop_rsp valid=%b ch=%0d cmd=%b data=%h id=%h err=%b expected 1 3 11 0 0 0",
                     rsp_valid, rsp_ch, rsp_cmd, rsp_data, rsp_id, rsp_err);
        end
    endtask

    task automatic test_reserved();
        ch_valid = 4'b0001;
        ch_cmd   = 8'b00_00_00_00;
        #1;
        checks++;
        if (ch_ready !== 4'b0001 || pq_push !== 1'b0 || pq_pop !== 1'b0 || pq_drop !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_grant ready=%b push=%b pop=%b drop=%b expected 0001 0 0 0",
                     ch_ready, pq_push, pq_pop, pq_drop);
        end
        @(posedge clk);
        #1 ch_valid = 4'h0;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_ch !== 2'd0 || rsp_cmd !== 2'b00) begin
            errors++;
            $display("FAIL rsvd_rsp valid=%b err=%b ch=%0d cmd=%b expected 1 1 0 00",
                     rsp_valid, rsp_err, rsp_ch, rsp_cmd);
        end
    endtask

    task automatic test_flush();
        int pops = 0;
        ch_valid = 4'b0001;
        ch_cmd   = 8'b00_00_00_01;
        empty    = 1'b0;
        flush    = 1'b1;
        #1;
        checks++;
        if (ch_ready !== 4'h0 || pq_push !== 1'b0 || pq_pop !== 1'b0) begin
            errors++;
            $display("FAIL flush_wins ready=%b push=%b pop=%b expected 0000 0 0", ch_ready, pq_push, pq_pop);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (pq_pop === 1'b1) pops++;
            checks++;
            if (pq_pop !== 1'b1 || ch_ready !== 4'h0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_pop k=%0d pop=%b ready=%b busy=%b rsp_valid=%b expected 1 0000 1 0",
                         k, pq_pop, ch_ready, busy, rsp_valid);
            end
            @(posedge clk);
            #1;
            if (k == 2) empty = 1'b1;
            #1;
        end
        checks++;
        if (pops != 3 || pq_pop !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_drained pops=%0d pop=%b busy=%b expected 3 0 1", pops, pq_pop, busy);
        end
        @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || ch_ready !== 4'b0001 || pq_push !== 1'b1) begin
            errors++;
            $display("FAIL flush_resume busy=%b ready=%b push=%b expected 0 0001 1", busy, ch_ready, pq_push);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #2;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_ch !== 2'd0) begin
            errors++;
            $display("FAIL pre_reset_rsp valid=%b ch=%0d expected 1 0", rsp_valid, rsp_ch);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || ch_ready !== 4'h0 || pq_push !== 1'b0) begin
            errors++;
            $display("FAIL async_reset valid=%b busy=%b ready=%b push=%b expected 0 1 0000 0",
                     rsp_valid, busy, ch_ready, pq_push);
        end
`ifdef PQ_ARB_STATS_EN
        checks++;
        if (grant_cnt !== '0) begin
            errors++;
            $display("FAIL grant_cnt_clear got=%h expected 0", grant_cnt);
        end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1 || ch_ready !== 4'h0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reinit busy=%b ready=%b rsp_valid=%b expected 1 0000 0", busy, ch_ready, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_push_rr();
        test_pop_wait();
        test_drop();
        test_reserved();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
